// File: rtl/grey_code6_rx.sv
// Receive side of the 6-bit grey increment link: synchronise the foreign grey bus,
// decode it to binary, pulse incr once per legal +1 step and count accepted steps.
module grey_code6_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       grey_in,
    input  logic             clr,
    input  logic             err_clr,
    output logic             valid,
    output logic [5:0]       binary,
    output logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int WAIT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [5:0]         sync_q [SYNC_STAGES];
    logic [5:0]         prev_q;
    logic [5:0]         binary_q;
    logic               incr_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_q;
    logic               valid_q;

    logic [5:0]         g_s;
    logic [5:0]         bin_d;
    logic [5:0]         diff;
    logic               moved;
    logic               one_bit;
    logic               step;
    logic               illegal;

    function automatic logic [5:0] grey2bin(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= grey_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Any change other than a single-bit +1 step is illegal; the baseline always
    // follows the bus so one glitch produces one error, not a stream of them.
    always_comb begin
        g_s     = sync_q[SYNC_STAGES-1];
        bin_d   = grey2bin(g_s);
        diff    = g_s ^ prev_q;
        moved   = |diff;
        one_bit = moved && ((diff & (diff - 6'd1)) == 6'd0);
        step    = one_bit && (bin_d == binary_q + 6'd1);
        illegal = moved && !step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= INIT;
            wait_q   <= '0;
            prev_q   <= '0;
            binary_q <= '0;
            incr_q   <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            incr_q <= 1'b0;
            case (state_q)
                INIT: begin
                    // Hold off until stale pre-reset zeros have left the synchroniser.
                    if (wait_q == WAIT_W'(SYNC_STAGES)) begin
                        prev_q   <= g_s;
                        binary_q <= bin_d;
                        valid_q  <= 1'b1;
                        state_q  <= TRACK;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                TRACK: begin
                    if (moved) begin
                        prev_q   <= g_s;
                        binary_q <= bin_d;
                    end
                    if (step) begin
                        incr_q <= 1'b1;
                    end
                    if (clr) begin
                        count_q <= '0;
                    end else if (step) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (illegal) begin
                        err_q <= 1'b1;
                    end else if (err_clr) begin
                        err_q <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign valid  = valid_q;
    assign binary = binary_q;
    assign incr   = incr_q;
    assign count  = count_q;
    assign err    = err_q;

endmodule
